wr_resp_direction_buffer: RTL and testbench
===========================================

# wr_resp_direction_buffer

Per-direction write-response queue placed directly downstream of the write-response direction decoder. It captures every one-cycle `v_wresp_vld[i]` pulse with its `wr_resp_pld_t` payload into a small FIFO for direction `i`. It then presents the oldest entry to that direction's master on a valid/ready handshake. The decoder has no backpressure, so this block exports `v_almost_full` for upstream request throttling and records any dropped response in a sticky overflow flag.

## Interface
- `WIDTH`, 4: number of directions; must match the decoder.
- `DEPTH`, 4: entries per direction FIFO; power of two, ≥2.
- `AF_THRESH`, `DEPTH-1`: occupancy at or above which `v_almost_full[i]` asserts; range 1..DEPTH.
- `CW` (localparam), `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `v_wresp_vld`  in  WIDTH: push strobe per direction, from the decoder.
- `v_wresp_pld`  in  `wr_resp_pld_t` [WIDTH]: push payload (`txnid`, `sideband`) per direction.
- `v_out_vld`  out  WIDTH: head entry valid per direction.
- `v_out_pld`  out  `wr_resp_pld_t` [WIDTH]: head entry payload; all-zero when `v_out_vld[i]`=0.
- `v_out_rdy`  in  WIDTH: master accepts head entry.
- `v_almost_full`  out  WIDTH: occupancy ≥ `AF_THRESH`.
- `v_count`  out  `[CW-1:0]` [WIDTH]: current occupancy per direction.
- `v_overflow`  out  WIDTH: sticky flag; a push was dropped because the FIFO was full.

## Operation
- The `WIDTH` FIFOs are fully independent; there is no cross-direction arbitration.
- Each FIFO holds `mem[DEPTH]`, `wr_ptr`/`rd_ptr` of `$clog2(DEPTH)` bits wrapping modulo `DEPTH`, and `count` of `CW` bits.
- Push: `push = v_wresp_vld[i] && (count<DEPTH || pop)`.
  - On push, `mem[wr_ptr]` is written with `v_wresp_pld[i]` and `wr_ptr` increments.
- Pop: `pop = v_out_vld[i] && v_out_rdy[i]`. On pop, `rd_ptr` increments.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Full, push, no pop: the push is dropped. `mem`, `wr_ptr` and `count` are unchanged, and `v_overflow[i]` sets and stays set until `rst`.
- Full, push, pop in the same cycle: both occur; `count` stays `DEPTH` and no overflow is flagged.
- Empty, push: `v_out_vld` stays 0 that cycle. The push does not bypass to the output.
- `v_out_rdy[i]` while `v_out_vld[i]`=0: no effect.
- Outputs:
  - `v_out_vld[i] = (count!=0)`.
  - `v_out_pld[i] = v_out_vld[i] ? mem[rd_ptr] : '0`.
  - `v_almost_full[i] = (count >= AF_THRESH)`.
  - `v_count[i] = count`.
  - All are combinational from registered state only. There is no combinational path from any input to any output.
- Order: strict FIFO per direction; `txnid` order at the output equals push order.

## Timing
- Reset (async assert, any cycle, including mid-traffic):
  - `count`, pointers and `v_overflow` clear to 0.
  - `v_out_vld`=0, `v_out_pld`=0, `v_almost_full`=0 (given `AF_THRESH`≥1), `v_count`=0.
  - `mem` is not reset.
  - In-flight entries are discarded; no pop completes in a reset cycle.
- Push-to-output latency: 1 cycle. A push in cycle N gives `v_out_vld`=1 in N+1.
- Back-to-back throughput: one push and one pop per direction per cycle, sustained.
- `v_out_vld`/`v_out_pld` hold stable while `v_out_rdy`=0. They change only after a pop or a push into an empty FIFO.
- `v_almost_full` reflects `count` after the previous edge. Upstream must stop issuing writes to that direction within `DEPTH-AF_THRESH` cycles of assertion to avoid overflow.

## Test plan
- Reset then single push to dir 2 (txnid 0x12) with `v_out_rdy`=1 → `v_out_vld`=4'b0100 one cycle later with txnid 0x12. Popped that cycle, then `v_count[2]`=0.
- Push 4 to dir 0 (txnids 1,2,3,4) with `rdy`=0:
  - `v_almost_full[0]` rises after the 3rd push and `v_count[0]`=4.
  - A 5th push (txnid 5) → `v_overflow[0]`=1 and entry 5 is absent.
  - Draining yields 1,2,3,4.
- Dir 1 full, simultaneous push (txnid 9) and pop → `count` stays 4, no overflow, and the last drained entry is 9.
- Pushes to all 4 directions every cycle for 20 cycles with random `rdy` per direction → per-direction order preserved, no cross-direction leakage, and overflow only where `count` hit 4 without a pop.
- Assert `rst` with dir 3 holding 3 entries and overflow set → all outputs 0 immediately, and the next push appears 1 cycle later as the sole entry.
- `v_out_rdy`=1 while empty for 5 cycles → no pointer movement, and `v_count` stays 0.

Source files
------------

// File: rtl/wr_resp_direction_buffer.sv
// Per-direction write-response FIFOs behind the write-response decoder.
// Each direction buffers pushes and hands the oldest entry to its master on valid/ready.
package wr_resp_pkg;
  typedef struct packed {
    logic [7:0] txnid;
    logic [3:0] sideband;
  } wr_resp_pld_t;
endpackage

module wr_resp_direction_buffer
  import wr_resp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     v_wresp_vld,
  input  wr_resp_pld_t         v_wresp_pld [WIDTH],
  output logic [WIDTH-1:0]     v_out_vld,
  output wr_resp_pld_t         v_out_pld [WIDTH],
  input  logic [WIDTH-1:0]     v_out_rdy,
  output logic [WIDTH-1:0]     v_almost_full,
  output logic [CW-1:0]        v_count [WIDTH],
  output logic [WIDTH-1:0]     v_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  for (genvar i = 0; i < WIDTH; i++) begin : g_dir
    wr_resp_pld_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          push;
    logic          pop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = (count != '0) && v_out_rdy[i];
    assign push = v_wresp_vld[i] && ((count != DEPTH_C) || pop);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (v_wresp_vld[i] && !push) ovf <= 1'b1;
      end
    end

    // Storage is deliberately left out of reset; validity comes from count.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= v_wresp_pld[i];
    end

    assign v_out_vld[i]     = (count != '0);
    assign v_out_pld[i]     = (count != '0) ? mem[rd_ptr] : '0;
    assign v_almost_full[i] = (count >= AF_C);
    assign v_count[i]       = count;
    assign v_overflow[i]    = ovf;
  end

endmodule

// File: tb/tb_wr_resp_direction_buffer.sv
// Bench for wr_resp_direction_buffer: vector table for dir 0/2 fill, overflow and drain,
// plus hand sequences for full push+pop, random traffic, mid-traffic reset.
module tb_wr_resp_direction_buffer;
  import wr_resp_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   v_wresp_vld = '0;
  wr_resp_pld_t v_wresp_pld [4];
  logic [3:0]   v_out_vld;
  wr_resp_pld_t v_out_pld [4];
  logic [3:0]   v_out_rdy = '0;
  logic [3:0]   v_almost_full;
  logic [2:0]   v_count [4];
  logic [3:0]   v_overflow;

  int n_pass = 0;
  int n_total = 0;

  wr_resp_direction_buffer dut (
    .clk(clk), .rst(rst),
    .v_wresp_vld(v_wresp_vld), .v_wresp_pld(v_wresp_pld),
    .v_out_vld(v_out_vld), .v_out_pld(v_out_pld), .v_out_rdy(v_out_rdy),
    .v_almost_full(v_almost_full), .v_count(v_count), .v_overflow(v_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld, rdy;
    logic [7:0] t0, t2;
    logic [3:0] e_vld, e_af, e_ovf;
    logic [2:0] e_cnt0, e_cnt2;
    logic [7:0] e_h0, e_h2;
  } vec_t;

  function automatic wr_resp_pld_t mk(input logic [7:0] t);
    wr_resp_pld_t p;
    p.txnid = t;
    p.sideband = t[3:0] ^ 4'hA;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    v_wresp_vld = '0;
    v_out_rdy = '0;
    for (int i = 0; i < 4; i++) v_wresp_pld[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vt [16];
  logic [7:0] q [4][$];
  logic [3:0] ovf_m;
  logic [3:0] rdy_r;
  logic [3:0] pop_m;
  logic [7:0] seq;

  initial begin
    vt[0]  = '{4'b0100, 4'b0100, 8'h00, 8'h12, 4'b0100, 4'b0000, 4'b0000, 3'd0, 3'd1, 8'h00, 8'h12};
    vt[1]  = '{4'b0000, 4'b0100, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 3'd0, 3'd0, 8'h00, 8'h00};
    vt[2]  = '{4'b0001, 4'b0000, 8'h01, 8'h00, 4'b0001, 4'b0000, 4'b0000, 3'd1, 3'd0, 8'h01, 8'h00};
    vt[3]  = '{4'b0001, 4'b0000, 8'h02, 8'h00, 4'b0001, 4'b0000, 4'b0000, 3'd2, 3'd0, 8'h01, 8'h00};
    vt[4]  = '{4'b0001, 4'b0000, 8'h03, 8'h00, 4'b0001, 4'b0001, 4'b0000, 3'd3, 3'd0, 8'h01, 8'h00};
    vt[5]  = '{4'b0001, 4'b0000, 8'h04, 8'h00, 4'b0001, 4'b0001, 4'b0000, 3'd4, 3'd0, 8'h01, 8'h00};
    vt[6]  = '{4'b0001, 4'b0000, 8'h05, 8'h00, 4'b0001, 4'b0001, 4'b0001, 3'd4, 3'd0, 8'h01, 8'h00};
    vt[7]  = '{4'b0000, 4'b0001, 8'h00, 8'h00, 4'b0001, 4'b0001, 4'b0001, 3'd3, 3'd0, 8'h02, 8'h00};
    vt[8]  = '{4'b0000, 4'b0001, 8'h00, 8'h00, 4'b0001, 4'b0000, 4'b0001, 3'd2, 3'd0, 8'h03, 8'h00};
    vt[9]  = '{4'b0000, 4'b0001, 8'h00, 8'h00, 4'b0001, 4'b0000, 4'b0001, 3'd1, 3'd0, 8'h04, 8'h00};
    vt[10] = '{4'b0000, 4'b0001, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0001, 3'd0, 3'd0, 8'h00, 8'h00};
    for (int k = 11; k < 16; k++)
      vt[k] = '{4'b0000, 4'b1111, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0001, 3'd0, 3'd0, 8'h00, 8'h00};

    // Reset state
    do_reset();
    chk("rst_vld", 32'(v_out_vld), 32'h0);
    chk("rst_af", 32'(v_almost_full), 32'h0);
    chk("rst_ovf", 32'(v_overflow), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_cnt%0d", i), 32'(v_count[i]), 32'h0);

    // Vector table
    for (int k = 0; k < 16; k++) begin
      v_wresp_vld = vt[k].vld;
      v_out_rdy = vt[k].rdy;
      v_wresp_pld[0] = mk(vt[k].t0);
      v_wresp_pld[2] = mk(vt[k].t2);
      step();
      chk($sformatf("v%0d_vld", k), 32'(v_out_vld), 32'(vt[k].e_vld));
      chk($sformatf("v%0d_af", k), 32'(v_almost_full), 32'(vt[k].e_af));
      chk($sformatf("v%0d_ovf", k), 32'(v_overflow), 32'(vt[k].e_ovf));
      chk($sformatf("v%0d_cnt0", k), 32'(v_count[0]), 32'(vt[k].e_cnt0));
      chk($sformatf("v%0d_cnt2", k), 32'(v_count[2]), 32'(vt[k].e_cnt2));
      chk($sformatf("v%0d_pld0", k), 32'(v_out_pld[0]),
          vt[k].e_vld[0] ? 32'(mk(vt[k].e_h0)) : 32'h0);
      chk($sformatf("v%0d_pld2", k), 32'(v_out_pld[2]),
          vt[k].e_vld[2] ? 32'(mk(vt[k].e_h2)) : 32'h0);
    end

    // Dir 1 full, simultaneous push and pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v_wresp_vld = 4'b0010;
      v_wresp_pld[1] = mk(8'h21 + 8'(k));
      step();
    end
    chk("full1_cnt", 32'(v_count[1]), 32'd4);
    v_wresp_pld[1] = mk(8'h29);
    v_out_rdy = 4'b0010;
    step();
    clear_inputs();
    chk("full1_pp_cnt", 32'(v_count[1]), 32'd4);
    chk("full1_pp_ovf", 32'(v_overflow), 32'h0);
    begin
      logic [7:0] exp_d [4];
      exp_d = '{8'h22, 8'h23, 8'h24, 8'h29};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("full1_drain%0d", k), 32'(v_out_pld[1]), 32'(mk(exp_d[k])));
        v_out_rdy = 4'b0010;
        step();
      end
      v_out_rdy = '0;
      chk("full1_empty", 32'(v_out_vld), 32'h0);
    end

    // Random traffic on all directions against a queue model
    do_reset();
    ovf_m = '0;
    seq = '0;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int c = 0; c < 20; c++) begin
      rdy_r = 4'($urandom_range(0, 15));
      v_wresp_vld = 4'b1111;
      v_out_rdy = rdy_r;
      for (int i = 0; i < 4; i++) v_wresp_pld[i] = mk({2'(i), seq[5:0]});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rnd%0d_vld%0d", c, i), 32'(v_out_vld[i]), 32'(q[i].size() != 0));
        chk($sformatf("rnd%0d_pld%0d", c, i), 32'(v_out_pld[i]),
            (q[i].size() != 0) ? 32'(mk(q[i][0])) : 32'h0);
      end
      step();
      for (int i = 0; i < 4; i++) begin
        pop_m[i] = (q[i].size() != 0) && rdy_r[i];
        if (pop_m[i]) void'(q[i].pop_front());
        if (q[i].size() < 4) q[i].push_back({2'(i), seq[5:0]});
        else ovf_m[i] = 1'b1;
        chk($sformatf("rnd%0d_cnt%0d", c, i), 32'(v_count[i]), 32'(q[i].size()));
      end
      chk($sformatf("rnd%0d_ovf", c), 32'(v_overflow), 32'(ovf_m));
      seq++;
    end
    clear_inputs();

    // Mid-traffic reset with dir 3 holding 3 entries and overflow set
    do_reset();
    for (int k = 0; k < 5; k++) begin
      v_wresp_vld = 4'b1000;
      v_wresp_pld[3] = mk(8'h30 + 8'(k));
      step();
    end
    v_wresp_vld = '0;
    v_out_rdy = 4'b1000;
    step();
    v_out_rdy = '0;
    chk("pre_rst_cnt3", 32'(v_count[3]), 32'd3);
    chk("pre_rst_ovf", 32'(v_overflow), 32'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(v_out_vld), 32'h0);
    chk("async_rst_ovf", 32'(v_overflow), 32'h0);
    chk("async_rst_cnt3", 32'(v_count[3]), 32'h0);
    chk("async_rst_pld3", 32'(v_out_pld[3]), 32'h0);
    chk("async_rst_af", 32'(v_almost_full), 32'h0);
    #1 rst = 1'b0;
    step();
    v_wresp_vld = 4'b1000;
    v_wresp_pld[3] = mk(8'h77);
    chk("post_rst_nobypass", 32'(v_out_vld), 32'h0);
    step();
    v_wresp_vld = '0;
    chk("post_rst_vld", 32'(v_out_vld), 32'b1000);
    chk("post_rst_cnt3", 32'(v_count[3]), 32'd1);
    chk("post_rst_pld3", 32'(v_out_pld[3]), 32'(mk(8'h77)));
    v_out_rdy = 4'b1000;
    step();
    v_out_rdy = '0;
    chk("post_rst_sole", 32'(v_out_vld), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
